// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and default widths for the instruction fetch stage
package fetch_pkg;

  localparam int ADDR_W          = 8;
  localparam int DATA_W          = 8;
  localparam int INSTR_W         = 32;
  localparam int BYTES_PER_INSTR = INSTR_W / DATA_W;

  typedef enum logic [0:0] {
    FETCH    = 1'b0,
    WAIT_OUT = 1'b1
  } fetch_state_e;

  typedef logic [INSTR_W-1:0] instr_t;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - ROM port, redirect and decode handshake bundle for the fetch stage
interface instr_fetch_if #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int INSTR_WIDTH   = 32
);

  logic [ADDRESS_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0]    rom_data;
  logic                     redirect_valid;
  logic [ADDRESS_WIDTH-1:0] redirect_pc;
  logic                     instr_valid;
  logic [INSTR_WIDTH-1:0]   instr;
  logic [ADDRESS_WIDTH-1:0] instr_pc;
  logic                     instr_ready;

  // Fetch stage side
  modport master (
    output rom_addr,
    input  rom_data,
    input  redirect_valid,
    input  redirect_pc,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  // ROM / decode / branch-unit side
  modport slave (
    input  rom_addr,
    output rom_data,
    output redirect_valid,
    output redirect_pc,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - byte-serial instruction fetch with little-endian assembly and one-entry output slot
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = ADDR_W,
  parameter int                       DATA_WIDTH    = DATA_W,
  parameter int                       INSTR_WIDTH   = INSTR_W,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input logic            clk,
  input logic            rst,
  instr_fetch_if.master  bus
);

  localparam int N  = INSTR_WIDTH / DATA_WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]            LAST_BYTE = CW'(N - 1);
  localparam logic [ADDRESS_WIDTH-1:0] PC_STEP   = ADDRESS_WIDTH'(N);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MSK = ~ADDRESS_WIDTH'(N - 1);

  if ((INSTR_WIDTH % DATA_WIDTH) != 0 || N < 2 || (N & (N - 1)) != 0) begin : g_param_check
    $error("instr_fetch: INSTR_WIDTH must be a power-of-two multiple (>=2) of DATA_WIDTH");
  end

  fetch_state_e                  state_q, state_d;
  logic [ADDRESS_WIDTH-1:0]      fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]                 byte_cnt_q, byte_cnt_d;
  logic [N-1:0][DATA_WIDTH-1:0]  asm_q, asm_d;
  logic                          instr_valid_q, instr_valid_d;
  logic [INSTR_WIDTH-1:0]        instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0]      instr_pc_q, instr_pc_d;
  logic                          slot_free;

  // The ROM address is a pure function of registered state, never of inputs
  assign bus.rom_addr    = fetch_pc_q + ADDRESS_WIDTH'(byte_cnt_q);
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign slot_free       = !instr_valid_q || bus.instr_ready;

  // Next-state: byte assembly, slot hand-off, stall on a full slot, redirect flush
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    byte_cnt_d    = byte_cnt_q;
    asm_d         = asm_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;

    if (instr_valid_q && bus.instr_ready) begin
      instr_valid_d = 1'b0;
    end

    unique case (state_q)
      FETCH: begin
        if (byte_cnt_q != LAST_BYTE) begin
          asm_d[byte_cnt_q] = bus.rom_data;
          byte_cnt_d        = byte_cnt_q + 1'b1;
        end else if (slot_free) begin
          instr_d       = {bus.rom_data, asm_q[N-2:0]};
          instr_pc_d    = fetch_pc_q;
          instr_valid_d = 1'b1;
          fetch_pc_d    = fetch_pc_q + PC_STEP;
          byte_cnt_d    = '0;
        end else begin
          // Park the last byte and hold rom_addr until decode drains the slot
          asm_d[N-1] = bus.rom_data;
          state_d    = WAIT_OUT;
        end
      end
      WAIT_OUT: begin
        if (bus.instr_ready) begin
          instr_d       = asm_q;
          instr_pc_d    = fetch_pc_q;
          instr_valid_d = 1'b1;
          fetch_pc_d    = fetch_pc_q + PC_STEP;
          byte_cnt_d    = '0;
          state_d       = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase

    // A redirect discards partial work and never reloads the slot in its cycle
    if (bus.redirect_valid) begin
      fetch_pc_d    = bus.redirect_pc & ALIGN_MSK;
      byte_cnt_d    = '0;
      state_d       = FETCH;
      instr_valid_d = 1'b0;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
    end
  end

  // State registers with synchronous reset overriding everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      fetch_pc_q    <= RESET_PC;
      byte_cnt_q    <= '0;
      asm_q         <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      byte_cnt_q    <= byte_cnt_d;
      asm_q         <= asm_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with directed cases and a random scoreboard run
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  instr_fetch_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .INSTR_WIDTH(IW)) bus ();

  instr_fetch #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .INSTR_WIDTH  (IW),
    .RESET_PC     (8'h00)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [256];
  assign bus.rom_data = rom[bus.rom_addr];

  int n_checks = 0;
  int n_pass   = 0;
  int n_xfer   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic instr_t rom_word(input logic [7:0] pc);
    instr_t     w;
    logic [7:0] a;
    for (int i = 0; i < 4; i++) begin
      a = pc + 8'(i);
      w[8*i +: 8] = rom[a];
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect_valid = 1'b0;
    step();
    step();
    check("rst_valid", bus.instr_valid, 1'b0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_pc", bus.instr_pc, 8'h00);
    check("rst_addr", bus.rom_addr, 8'h00);
    rst = 1'b0;
  endtask

  // Transaction-level reference: decode must see words at consecutive aligned
  // addresses, restarting at the aligned redirect target; a stalled slot must hold.
  logic [7:0] exp_pc;
  logic       hold_pend;
  instr_t     hold_instr;
  logic [7:0] hold_pc;

  initial begin
    exp_pc    = 8'h00;
    hold_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_pc    = 8'h00;
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("hold_valid", bus.instr_valid, 1'b1);
          check("hold_instr", bus.instr, hold_instr);
          check("hold_pc", bus.instr_pc, hold_pc);
        end
        hold_pend  = bus.instr_valid && !bus.instr_ready && !bus.redirect_valid;
        hold_instr = bus.instr;
        hold_pc    = bus.instr_pc;
        if (bus.instr_valid && bus.instr_ready) begin
          n_xfer++;
          check("xfer_pc", bus.instr_pc, exp_pc);
          check("xfer_instr", bus.instr, rom_word(exp_pc));
          exp_pc = exp_pc + 8'd4;
        end
        if (bus.redirect_valid) exp_pc = bus.redirect_pc & 8'hFC;
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[0] = 8'h13; rom[1] = 8'h05; rom[2] = 8'h10; rom[3] = 8'h00;
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 8'h00;

    // Streaming with ready held high: latency N, cadence N
    do_reset();
    for (int k = 0; k < 4; k++) begin
      check("t1_addr", bus.rom_addr, 64'(k));
      check("t1_idle", bus.instr_valid, 1'b0);
      step();
    end
    check("t1_valid", bus.instr_valid, 1'b1);
    check("t1_instr", bus.instr, 32'h00100513);
    check("t1_pc", bus.instr_pc, 8'h00);
    step();
    for (int k = 5; k < 8; k++) begin
      check("t1_gap", bus.instr_valid, 1'b0);
      step();
    end
    check("t1_valid2", bus.instr_valid, 1'b1);
    check("t1_pc2", bus.instr_pc, 8'h04);

    // Back-pressure: second word parks in WAIT_OUT at rom_addr 7
    bus.instr_ready = 1'b0;
    do_reset();
    repeat (4) step();
    check("t2_valid", bus.instr_valid, 1'b1);
    check("t2_pc", bus.instr_pc, 8'h00);
    repeat (4) step();
    check("t2_wait_addr", bus.rom_addr, 8'h07);
    check("t2_wait_pc", bus.instr_pc, 8'h00);
    step();
    step();
    check("t2_wait_addr2", bus.rom_addr, 8'h07);
    bus.instr_ready = 1'b1;
    step();
    check("t2_next_valid", bus.instr_valid, 1'b1);
    check("t2_next_pc", bus.instr_pc, 8'h04);
    check("t2_next_addr", bus.rom_addr, 8'h08);

    // Mid-word redirect to an unaligned target
    do_reset();
    step();
    step();
    check("t3_addr2", bus.rom_addr, 8'h02);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h41;
    step();
    bus.redirect_valid = 1'b0;
    check("t3_addr", bus.rom_addr, 8'h40);
    check("t3_flush", bus.instr_valid, 1'b0);
    repeat (4) step();
    check("t3_valid", bus.instr_valid, 1'b1);
    check("t3_pc", bus.instr_pc, 8'h40);
    check("t3_instr", bus.instr, rom_word(8'h40));

    // Redirect near the top of the address space: PC wraps to 0
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'hFC;
    step();
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t4_addr", bus.rom_addr, 64'(8'hFC + 8'(k)));
      step();
    end
    check("t4_pc", bus.instr_pc, 8'hFC);
    check("t4_wrap_addr", bus.rom_addr, 8'h00);
    repeat (4) step();
    check("t4_wrap_valid", bus.instr_valid, 1'b1);
    check("t4_wrap_pc", bus.instr_pc, 8'h00);

    // Redirect coincident with a transfer: slot empties and stays empty
    do_reset();
    repeat (4) step();
    check("t5_valid", bus.instr_valid, 1'b1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h80;
    step();
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t5_squash", bus.instr_valid, 1'b0);
      step();
    end
    check("t5_pc", bus.instr_pc, 8'h80);

    // Reset while parked in WAIT_OUT with a full slot
    bus.instr_ready = 1'b0;
    do_reset();
    repeat (8) step();
    check("t6_wait_addr", bus.rom_addr, 8'h07);
    check("t6_full", bus.instr_valid, 1'b1);
    rst = 1'b1;
    step();
    check("t6_valid", bus.instr_valid, 1'b0);
    check("t6_instr", bus.instr, 32'h0);
    check("t6_addr", bus.rom_addr, 8'h00);
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    repeat (4) step();
    check("t6_resume", bus.instr_valid, 1'b1);
    check("t6_resume_pc", bus.instr_pc, 8'h00);

    // Random ready / redirect / reset traffic against the scoreboard
    n_xfer = 0;
    for (int c = 0; c < 4000; c++) begin
      bus.instr_ready    = ($urandom % 4) != 0;
      bus.redirect_valid = ($urandom % 24) == 0;
      bus.redirect_pc    = 8'($urandom);
      rst                = ($urandom % 600) == 0;
      step();
    end
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    step();
    check("rand_progress", 64'(n_xfer > 300), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
